// File: rtl/i2c_reg_slave.sv
// I2C target modelling a register-mapped sensor: pointer write, then data writes or repeated-start reads.
// Define I2C_REG_SLAVE_STRETCH_EN to hold SCL low for STRETCH_CYCLES after every ACK bit.
module i2c_reg_slave #(
  parameter logic [6:0] DEV_ADDR       = 7'h68,
  parameter int         REG_COUNT      = 128,
  parameter int         FILTER_LEN     = 4,
  parameter int         STRETCH_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  input  logic       loc_wr_en,
  input  logic [7:0] loc_wr_addr,
  input  logic [7:0] loc_wr_data,
  output logic       bus_wr_strobe,
  output logic [7:0] bus_wr_addr,
  output logic [7:0] bus_wr_data,
  output logic       busy,
  output logic [3:0] dbg_state_o
);
  localparam int PW = $clog2(REG_COUNT);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0, ST_ADDR = 4'd1, ST_ADDR_ACK = 4'd2, ST_PTR = 4'd3, ST_PTR_ACK = 4'd4,
    ST_WR = 4'd5, ST_WR_ACK = 4'd6, ST_RD = 4'd7, ST_MACK = 4'd8, ST_IGNORE = 4'd9
  } state_e;

  logic [1:0]    scl_sync_q, sda_sync_q;
  logic [FW-1:0] scl_cnt_q, sda_cnt_q;
  logic          scl_f_q, sda_f_q, scl_p_q, sda_p_q;

  // A filtered level only flips after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_p_q    <= scl_f_q;
      sda_p_q    <= sda_f_q;
      if (scl_sync_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == FW'(FILTER_LEN - 1)) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 1'b1;
      end
      if (sda_sync_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == FW'(FILTER_LEN - 1)) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 1'b1;
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          sda_drv_q, sda_drv_d, busy_q, busy_d, rw_q, rw_d, mack_q, mack_d;
  logic          strobe_q, strobe_d, load_rd;
  logic [7:0]    wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_byte;
  logic [7:0]    regs_q [REG_COUNT];

  assign rd_byte = regs_q[ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_drv_q <= 1'b1;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b1;
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_drv_q <= sda_drv_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Receive states shift on SCL rise; every SDA change is made on the detected SCL fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_drv_d = sda_drv_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    load_rd   = 1'b0;
    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_drv_d = 1'b1;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      sda_drv_d = 1'b1;
      bit_cnt_d = '0;
    end else if (scl_rise) begin
      if ((state_q == ST_ADDR || state_q == ST_PTR || state_q == ST_WR) && bit_cnt_q != 4'd8) begin
        shift_d   = {shift_q[6:0], sda_f_q};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      if (state_q == ST_MACK) mack_d = sda_f_q;
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          if (shift_q[7:1] == DEV_ADDR) begin
            state_d   = ST_ADDR_ACK;
            sda_drv_d = 1'b0;
            busy_d    = 1'b1;
            rw_d      = shift_q[0];
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_PTR: if (bit_cnt_q == 4'd8) begin
          ptr_d     = shift_q[PW-1:0];
          sda_drv_d = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_PTR_ACK;
        end
        ST_WR: if (bit_cnt_q == 4'd8) begin
          strobe_d  = 1'b1;
          wr_addr_d = 8'(ptr_q);
          wr_data_d = shift_q;
          ptr_d     = ptr_q + 1'b1;
          sda_drv_d = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_WR_ACK;
        end
        ST_ADDR_ACK: begin
          if (rw_q) begin
            load_rd = 1'b1;
          end else begin
            sda_drv_d = 1'b1;
            state_d   = ST_PTR;
          end
        end
        ST_PTR_ACK, ST_WR_ACK: begin
          sda_drv_d = 1'b1;
          state_d   = ST_WR;
        end
        ST_RD: begin
          if (bit_cnt_q == 4'd8) begin
            sda_drv_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_MACK;
          end else begin
            sda_drv_d = shift_q[6];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_MACK: begin
          if (!mack_q) begin
            load_rd = 1'b1;
          end else begin
            sda_drv_d = 1'b1;
            state_d   = ST_IGNORE;
          end
        end
        default: ;
      endcase
      // Read byte is snapshotted here, so later local writes cannot alter it mid-flight.
      if (load_rd) begin
        shift_d   = rd_byte;
        sda_drv_d = rd_byte[7];
        ptr_d     = ptr_q + 1'b1;
        bit_cnt_d = 4'd1;
        state_d   = ST_RD;
      end
    end
  end

  logic [PW-1:0] loc_idx;
  logic          unused_loc_addr;
  assign loc_idx         = loc_wr_addr[PW-1:0];
  assign unused_loc_addr = ^loc_wr_addr;

  // Bus store lands in the strobe cycle and beats a same-address local write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'h00;
    end else begin
      if (strobe_q) regs_q[wr_addr_q[PW-1:0]] <= wr_data_q;
      if (loc_wr_en && !(strobe_q && loc_idx == wr_addr_q[PW-1:0])) regs_q[loc_idx] <= loc_wr_data;
    end
  end

`ifdef I2C_REG_SLAVE_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  logic [SW-1:0] str_cnt_q;
  logic          scl_low_q, ack_end;
  assign ack_end = scl_fall & ~start_det & ~stop_det &
                   (state_q == ST_ADDR_ACK || state_q == ST_PTR_ACK ||
                    state_q == ST_WR_ACK || state_q == ST_MACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      str_cnt_q <= '0;
      scl_low_q <= 1'b0;
    end else if (ack_end) begin
      str_cnt_q <= SW'(STRETCH_CYCLES - 1);
      scl_low_q <= 1'b1;
    end else if (scl_low_q) begin
      if (str_cnt_q == '0) scl_low_q <= 1'b0;
      else str_cnt_q <= str_cnt_q - 1'b1;
    end
  end
  assign scl_o = ~scl_low_q;
  assign scl_t = ~scl_low_q;
`else
  assign scl_o = 1'b1;
  assign scl_t = 1'b1;
`endif

  assign sda_o         = sda_drv_q;
  assign sda_t         = sda_drv_q;
  assign bus_wr_strobe = strobe_q;
  assign bus_wr_addr   = wr_addr_q;
  assign bus_wr_data   = wr_data_q;
  assign busy          = busy_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master on a wired-AND bus, scoreboards for stores and read bytes.
module tb_i2c_reg_slave;
  localparam int         Q      = 12;
  localparam logic [6:0] DEV    = 7'h68;
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RD   = 4'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  logic       scl_bus, sda_bus;
  logic       scl_o, scl_t, sda_o, sda_t;
  logic       loc_wr_en = 1'b0;
  logic [7:0] loc_wr_addr = '0, loc_wr_data = '0;
  logic       bus_wr_strobe, busy;
  logic [7:0] bus_wr_addr, bus_wr_data;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int sda_low_cnt = 0;
  int busy_hi_cnt = 0;

  logic [15:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic [7:0]  rd_obs;
  event        rd_ev;

  always #5 clk = ~clk;
  assign scl_bus = m_scl & scl_o;
  assign sda_bus = m_sda & sda_o;

  i2c_reg_slave dut (
    .clk(clk), .rst(rst),
    .scl_i(scl_bus), .scl_o(scl_o), .scl_t(scl_t),
    .sda_i(sda_bus), .sda_o(sda_o), .sda_t(sda_t),
    .loc_wr_en(loc_wr_en), .loc_wr_addr(loc_wr_addr), .loc_wr_data(loc_wr_data),
    .bus_wr_strobe(bus_wr_strobe), .bus_wr_addr(bus_wr_addr), .bus_wr_data(bus_wr_data),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Store monitor: every strobe must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (!sda_o) sda_low_cnt++;
    if (busy) busy_hi_cnt++;
    if (bus_wr_strobe) begin
      if (wr_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_wr: got addr=%0h data=%0h expected no store", bus_wr_addr, bus_wr_data);
      end else begin
        check("bus_wr", {16'h0, bus_wr_addr, bus_wr_data}, {16'h0, wr_exp_q.pop_front()});
      end
    end
  end

  initial begin
    forever begin
      @(rd_ev);
      if (rd_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data: got %0h expected no read", rd_obs);
      end else begin
        check("rd_data", {24'h0, rd_obs}, {24'h0, rd_exp_q.pop_front()});
      end
    end
  end

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic r);
    m_sda = b;
    qwait();
    m_scl = 1'b1;
    qwait();
    r = sda_bus;
    qwait();
    m_scl = 1'b0;
    qwait();
  endtask

  task automatic bus_start();
    m_sda = 1'b1;
    qwait();
    m_scl = 1'b1;
    qwait();
    m_sda = 1'b0;
    qwait();
    m_scl = 1'b0;
    qwait();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    qwait();
    m_scl = 1'b1;
    qwait();
    m_sda = 1'b1;
    qwait();
    qwait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
    clock_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic m_ack);
    logic r;
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    clock_bit(~m_ack, r);
    rd_obs = d;
    -> rd_ev;
  endtask

  task automatic loc_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_wr_en   = 1'b1;
    loc_wr_addr = a;
    loc_wr_data = d;
    @(negedge clk);
    loc_wr_en = 1'b0;
  endtask

  task automatic addr_ptr(input logic [7:0] ptr);
    logic ack;
    bus_start();
    write_byte({DEV, 1'b0}, ack);
    check("addr_w_ack", {31'h0, ack}, 32'h1);
    check("busy_in_txn", {31'h0, busy}, 32'h1);
    write_byte(ptr, ack);
    check("ptr_ack", {31'h0, ack}, 32'h1);
  endtask

  task automatic wr_txn(input logic [7:0] ptr, input int n, input logic [7:0] d0, input logic [7:0] d1);
    logic ack;
    logic [7:0] a, d;
    addr_ptr(ptr);
    a = ptr & 8'h7F;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : d1;
      wr_exp_q.push_back({a, d});
      write_byte(d, ack);
      check("data_ack", {31'h0, ack}, 32'h1);
      a = (a + 8'd1) & 8'h7F;
    end
    bus_stop();
    check("busy_after_stop", {31'h0, busy}, 32'h0);
  endtask

  task automatic rd_txn(input logic [7:0] ptr, input int n, input logic [7:0] e0, input logic [7:0] e1);
    logic ack;
    addr_ptr(ptr);
    bus_start();
    write_byte({DEV, 1'b1}, ack);
    check("addr_r_ack", {31'h0, ack}, 32'h1);
    for (int i = 0; i < n; i++) begin
      rd_exp_q.push_back((i == 0) ? e0 : e1);
      read_byte(i < n - 1);
    end
    bus_stop();
    check("busy_after_rd", {31'h0, busy}, 32'h0);
  endtask

  task automatic collide(input logic [7:0] a, input logic [7:0] d);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus_wr_strobe) break;
    end
    check("collide_strobe_seen", {31'h0, bus_wr_strobe}, 32'h1);
    loc_wr_en   = 1'b1;
    loc_wr_addr = a;
    loc_wr_data = d;
    @(negedge clk);
    loc_wr_en = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack, r;
    int   sda_snap, busy_snap;
    bit   found;
    repeat (5) @(negedge clk);
    check("rst_sda_o", {31'h0, sda_o}, 32'h1);
    check("rst_sda_t", {31'h0, sda_t}, 32'h1);
    check("rst_scl_o", {31'h0, scl_o}, 32'h1);
    check("rst_scl_t", {31'h0, scl_t}, 32'h1);
    check("rst_strobe", {31'h0, bus_wr_strobe}, 32'h0);
    check("rst_wr_addr", {24'h0, bus_wr_addr}, 32'h0);
    check("rst_wr_data", {24'h0, bus_wr_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_state", {28'h0, dbg_state}, {28'h0, S_IDLE});
    rst = 1'b0;
    repeat (5) @(negedge clk);

    loc_write(8'h3D, 8'h12);
    loc_write(8'h3E, 8'h34);
    rd_txn(8'h3E, 1, 8'h34, 8'h00);
    rd_txn(8'h3D, 1, 8'h12, 8'h00);

    sda_snap  = sda_low_cnt;
    busy_snap = busy_hi_cnt;
    bus_start();
    write_byte({7'h69, 1'b0}, ack);
    check("wrong_addr_ack", {31'h0, ack}, 32'h0);
    bus_stop();
    check("wrong_addr_sda_driven", sda_low_cnt - sda_snap, 32'h0);
    check("wrong_addr_busy", busy_hi_cnt - busy_snap, 32'h0);

    wr_txn(8'h7F, 2, 8'hA5, 8'h5A);
    rd_txn(8'h7F, 2, 8'hA5, 8'h5A);

    loc_write(8'h10, 8'h66);
    addr_ptr(8'h10);
    clock_bit(1'b1, r);
    clock_bit(1'b0, r);
    clock_bit(1'b1, r);
    clock_bit(1'b1, r);
    bus_stop();
    check("partial_state", {28'h0, dbg_state}, {28'h0, S_IDLE});
    check("partial_sda_t", {31'h0, sda_t}, 32'h1);
    check("partial_busy", {31'h0, busy}, 32'h0);
    rd_txn(8'h10, 1, 8'h66, 8'h00);

    fork
      wr_txn(8'h20, 1, 8'hC3, 8'h00);
      collide(8'h20, 8'h77);
    join
    fork
      wr_txn(8'h20, 1, 8'hC3, 8'h00);
      collide(8'h21, 8'h99);
    join
    rd_txn(8'h20, 2, 8'hC3, 8'h99);

    fork
      begin
        addr_ptr(8'h40);
        bus_start();
        write_byte({DEV, 1'b1}, ack);
        check("rst_test_addr_ack", {31'h0, ack}, 32'h1);
        for (int i = 0; i < 9; i++) clock_bit(1'b1, r);
        bus_stop();
      end
      begin
        found = 1'b0;
        for (int i = 0; i < 8000; i++) begin
          @(negedge clk);
          if (dbg_state == S_RD && sda_o == 1'b0) begin
            found = 1'b1;
            break;
          end
        end
        check("rst_test_zero_bit_seen", {31'h0, found}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sda_t", {31'h0, sda_t}, 32'h1);
        check("midrst_sda_o", {31'h0, sda_o}, 32'h1);
        check("midrst_scl_t", {31'h0, scl_t}, 32'h1);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_wr_addr", {24'h0, bus_wr_addr}, 32'h0);
        check("midrst_wr_data", {24'h0, bus_wr_data}, 32'h0);
        check("midrst_state", {28'h0, dbg_state}, {28'h0, S_IDLE});
        rst = 1'b0;
      end
    join
    rd_txn(8'h3D, 1, 8'h00, 8'h00);

    repeat (10) @(negedge clk);
    check("wr_queue_drained", wr_exp_q.size(), 32'h0);
    check("rd_queue_drained", rd_exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
- I2C target (responder) that models a register-mapped sensor, e.g. an IMU at 7'h68, on the FPGA side of the same open-drain bus.
- Exposes a byte-wide register file. The bus master reads and writes it using the standard pointer-then-data protocol: write the register address, then repeated-start read.
- A local write port lets surrounding logic load sensor values. This makes the block usable both as a simulation device model for the I2C master driver and as a synthesizable target.

Parameters:
- DEV_ADDR, 7'h68, 7-bit device address the block responds to.
- REG_COUNT, 128, number of 8-bit registers. Must be a power of 2, at most 256. Pointer width is log2(REG_COUNT).
- FILTER_LEN, 4, number of consecutive equal samples required before a synchronized SCL/SDA level is accepted.
- STRETCH_CYCLES, 64, clk cycles SCL is held low per stretch. Used only with the optional feature.

Ports:
- clk  in  1  system clock; must be at least 20x SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL pin level.
- scl_o  out  1  SCL drive value.
- scl_t  out  1  SCL tristate; 1 = released.
- sda_i  in  1  SDA pin level.
- sda_o  out  1  SDA drive value.
- sda_t  out  1  SDA tristate; 1 = released.
- loc_wr_en  in  1  local register write strobe.
- loc_wr_addr  in  8  local write address; upper bits beyond the pointer width are ignored.
- loc_wr_data  in  8  local write data.
- bus_wr_strobe  out  1  one-cycle pulse when a bus data byte is stored.
- bus_wr_addr  out  8  register address of that stored byte.
- bus_wr_data  out  8  data of that stored byte.
- busy  out  1  high from an address-matched START until STOP.

Behaviour:
- Open-drain pins: sda_o always equals sda_t, and likewise scl_o equals scl_t. Value 0 pulls the line low; value 1 releases it.
- Input conditioning: scl_i and sda_i pass through a 2-flop synchronizer, then the FILTER_LEN glitch filter. Edges are detected on the filtered levels.
- Bus conditions: START/Sr = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- Bit timing: data is sampled on the SCL rising edge. SDA is changed only in the cycle after the SCL falling edge is detected.
- States:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits, MSB first.
  - ADDR_ACK: on address match, drive ACK (SDA low) for one SCL period and go to PTR if R/W=0 or RD if R/W=1. On mismatch, stay released (NACK) and go to IGNORE.
  - PTR: receives 8 bits, loads the register pointer, ACKs, then goes to WR.
  - WR: receives a byte, ACKs, stores it at the pointer, pulses bus_wr_strobe, increments the pointer.
  - RD: loads the shift register from reg[pointer] at the SCL falling edge that ends the ACK, increments the pointer, drives 8 bits, releases SDA, goes to MACK.
  - MACK: samples the master's ACK. ACK (SDA low) returns to RD. NACK goes to IGNORE.
  - IGNORE: SDA released until the next START or STOP.
- START/Sr from any state returns to ADDR. The pointer is kept, so write-pointer then Sr-read works.
- STOP from any state returns to IDLE and releases SDA. A partial byte is discarded, with no store and no strobe.
- Pointer wraps from REG_COUNT-1 to 0 on both read and write.
- Read data is snapshotted at load. A local write landing after load does not change the in-flight byte.
- Simultaneous bus store and loc_wr_en to the same address: the bus write wins and the local write is dropped. Different addresses: both writes occur.
- Reset values:
  - all register contents = 8'h00, pointer = 0, state = IDLE;
  - sda_o = sda_t = 1, scl_o = scl_t = 1;
  - bus_wr_strobe = 0, bus_wr_addr = 0, bus_wr_data = 0, busy = 0.
- Reset asserted mid-transfer releases SDA in the cycle after rst is sampled.

Optional Feature:
- Macro: I2C_REG_SLAVE_STRETCH_EN.
- Defined: after the SCL falling edge that ends every ACK bit (address ACK, data ACK, master ACK on reads), the block drives SCL low for STRETCH_CYCLES clk cycles, then releases it. Bit sampling resumes only once the filtered SCL is seen high.
- Undefined: scl_o = scl_t = 1 constantly and no stretching logic is built.

Test Plan:
- Preload via the local port 0x3D=8'h12, 0x3E=8'h34. Master writes pointer 0x3E, Sr, reads one byte, NACK, STOP; then writes 0x3D, Sr, reads -> bytes 8'h34 then 8'h12, ACK on address and pointer, busy high only inside each transaction.
- Master addresses 7'h69 with write -> NACK on the address bit, no bus_wr_strobe, busy stays 0, SDA never driven.
- Write pointer 0x7F then data 8'hA5, 8'h5A -> reg[0x7F]=8'hA5 and reg[0x00]=8'h5A; two strobes with bus_wr_addr 0x7F then 0x00.
- STOP injected after 4 data bits of a write to 0x10 -> reg[0x10] unchanged, no strobe, state IDLE, SDA released.
- Local write to 0x20 in the same cycle as bus store 8'hC3 to 0x20 -> reg[0x20]=8'hC3. Local write to 0x21 in that cycle also lands.
- rst asserted while driving a 0 data bit -> sda_t = 1 on the next cycle, all outputs at reset values. With STRETCH_EN defined: SCL held low exactly 64 cycles after each ACK.
